// File: rtl/lsu_unit.sv
// lsu_unit - load/store unit sitting right after the execute-stage ALU.
//
// Purpose:
//   Takes the ALU result as the effective address and rs2 as store data.
//   Issues one word-aligned request per operation on a req/gnt/rvalid
//   data-memory bus, with byte strobes and lane-replicated write data.
//   Load data is sign- or zero-extended back to 32 bits. The core sees a
//   one-cycle done pulse, and busy stays high while an operation is in flight.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               request strobe, only looked at while busy=0
//   is_load, is_store   operation direction (exactly one must be set)
//   funct3              RV32I width/sign code
//   addr, store_data    effective address and rs2 value
//   busy, done, fault   in-flight flag, completion pulse, error flag with done
//   load_data           extended load result, held until the next load completes
//   mem_req/we/addr/wdata/wstrb  memory request side
//   mem_gnt/rvalid/rdata         memory response side
module lsu_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  // The last count value before the wait is abandoned, so exactly TIMEOUT
  // cycles are spent in REQ or WAIT.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic [31:0]       loadData_q, loadData_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       storeData_q, storeData_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              isLoad_q, isLoad_d;

  logic              accept;
  logic              funct3Legal;
  logic              misaligned;
  logic [31:0]       rdataShifted;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [31:0]       extData;
  logic              storeReq;

  // Request decode on the live inputs: legality and alignment decide whether
  // the bus is touched at all.
  always_comb begin
    accept      = (state_q == IDLE) && start && (is_load ^ is_store);
    funct3Legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: funct3Legal = 1'b1;
      3'b100, 3'b101:         funct3Legal = is_load;
      default:                funct3Legal = 1'b0;
    endcase
    // funct3[1:0] is 01 for halfwords and 10 for words, signed or not.
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  // Lane extraction of read data using the latched low address bits.
  always_comb begin
    rdataShifted = mem_rdata >> {addr_q[1:0], 3'b000};
    byteSel      = rdataShifted[7:0];
    halfSel      = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  extData = {{24{byteSel[7]}}, byteSel};
      3'b001:  extData = {{16{halfSel[15]}}, halfSel};
      3'b100:  extData = {24'h0, byteSel};
      3'b101:  extData = {16'h0, halfSel};
      default: extData = mem_rdata;
    endcase
  end

  // Next-state logic for the transaction FSM, the timeout counter and the
  // latched operands.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    loadData_d  = loadData_q;
    addr_d      = addr_q;
    storeData_d = storeData_q;
    funct3_d    = funct3_q;
    isLoad_d    = isLoad_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = addr;
          storeData_d = store_data;
          funct3_d    = funct3;
          isLoad_d    = is_load;
          if (funct3Legal && !misaligned) begin
            state_d = REQ;
            cnt_d   = '0;
            fault_d = 1'b0;
          end else begin
            state_d    = DONE;
            fault_d    = 1'b1;
            loadData_d = '0;
          end
        end
      end
      REQ: begin
        // A same-cycle rvalid is ignored here; only the grant is taken.
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = isLoad_q ? WAIT : DONE;
        end else if (cnt_q == CntLast) begin
          state_d    = DONE;
          fault_d    = 1'b1;
          loadData_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          loadData_d = extData;
          state_d    = DONE;
        end else if (cnt_q == CntLast) begin
          state_d    = DONE;
          fault_d    = 1'b1;
          loadData_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and operand registers; reset aborts any transaction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      loadData_q  <= '0;
      addr_q      <= '0;
      storeData_q <= '0;
      funct3_q    <= '0;
      isLoad_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      loadData_q  <= loadData_d;
      addr_q      <= addr_d;
      storeData_q <= storeData_d;
      funct3_q    <= funct3_d;
      isLoad_q    <= isLoad_d;
    end
  end

  // Bus and core outputs, all derived from registered state so they stay
  // stable for the whole REQ phase.
  always_comb begin
    storeReq  = (state_q == REQ) && !isLoad_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    fault     = (state_q == DONE) && fault_q;
    load_data = loadData_q;
    mem_req   = (state_q == REQ);
    mem_we    = storeReq;
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = '0;
    mem_wstrb = '0;
    if (storeReq) begin
      case (funct3_q[1:0])
        2'b00: begin
          mem_wstrb = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{storeData_q[7:0]}};
        end
        2'b01: begin
          mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{storeData_q[15:0]}};
        end
        default: begin
          mem_wstrb = 4'b1111;
          mem_wdata = storeData_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit - directed testbench for lsu_unit.
//
// Purpose:
//   Drives loads and stores through the unit and plays the memory side.
//   Expected completion results go into a queue when an operation is issued.
//   They are popped and compared when done is seen. Bus-side fields are
//   checked directly while the request is outstanding.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        fault;
    logic        checkLd;
    logic [31:0] ld;
  } exp_t;

  exp_t sb[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  lsu_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .busy(busy), .done(done), .fault(fault),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_fault"}, fault, 0);
    checkOutput({tag, "_ld"}, load_data, 0);
    checkOutput({tag, "_req"}, mem_req, 0);
    checkOutput({tag, "_we"}, mem_we, 0);
    checkOutput({tag, "_addr"}, mem_addr, 0);
    checkOutput({tag, "_wdata"}, mem_wdata, 0);
    checkOutput({tag, "_wstrb"}, mem_wstrb, 0);
  endtask

  task automatic pushExp(input logic f, input logic chk, input logic [31:0] ld);
    exp_t e;
    e.fault   = f;
    e.checkLd = chk;
    e.ld      = ld;
    sb.push_back(e);
  endtask

  // Presents one start strobe for a single cycle; returns on the falling
  // edge after acceptance.
  task automatic applyStimulus(input logic ld, input logic st,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] sd);
    @(negedge clk);
    start = 1'b1; is_load = ld; is_store = st;
    funct3 = f3; addr = a; store_data = sd;
    @(negedge clk);
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  // Memory model: grant after gntDelay cycles, then for loads return rdata
  // rvDelay cycles after the grant cycle.
  task automatic serveMem(input string tag, input int gntDelay, input logic isLd,
                          input int rvDelay, input logic [31:0] rdata,
                          input logic sameCycleRv);
    repeat (gntDelay) @(negedge clk);
    checkOutput({tag, "_req_held"}, mem_req, 1);
    mem_gnt = 1'b1;
    if (sameCycleRv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h7F7F7F7F;
    end
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (isLd) begin
      repeat (rvDelay) @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = '0;
    end
  endtask

  // Expects done at the current falling edge, compares it against the
  // scoreboard and then checks that the pulse lasts one cycle.
  task automatic checkDone(input string tag);
    exp_t e;
    checkOutput({tag, "_done"}, done, 1);
    if (sb.size() == 0) begin
      testsRun++;
      testsFailed++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_fault"}, fault, e.fault);
      if (e.checkLd) checkOutput({tag, "_ld"}, load_data, e.ld);
    end
    @(negedge clk);
    checkOutput({tag, "_pulse"}, done, 0);
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int  reqCycles;
    bit  found;
    rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = '0; addr = '0; store_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    #12 checkAllZero("reset");
    @(negedge clk) rst_n = 1'b1;

    // SW with immediate grant
    pushExp(0, 1, 32'h0);
    applyStimulus(0, 1, 3'b010, 32'h100, 32'hDEADBEEF);
    checkOutput("sw_busy", busy, 1);
    checkOutput("sw_we", mem_we, 1);
    checkOutput("sw_addr", mem_addr, 32'h100);
    checkOutput("sw_wstrb", mem_wstrb, 4'b1111);
    checkOutput("sw_wdata", mem_wdata, 32'hDEADBEEF);
    serveMem("sw", 0, 0, 0, 0, 0);
    checkDone("sw");

    // LB from the top byte lane, grant held off one cycle
    pushExp(0, 1, 32'hFFFFFF80);
    applyStimulus(1, 0, 3'b000, 32'h203, 0);
    checkOutput("lb_wstrb", mem_wstrb, 0);
    checkOutput("lb_we", mem_we, 0);
    checkOutput("lb_addr", mem_addr, 32'h200);
    serveMem("lb", 1, 1, 0, 32'h80123456, 0);
    checkDone("lb");

    // LBU, with a stray rvalid in the grant cycle that must be ignored
    pushExp(0, 1, 32'h00000080);
    applyStimulus(1, 0, 3'b100, 32'h203, 0);
    serveMem("lbu", 0, 1, 0, 32'h80123456, 1);
    checkDone("lbu");

    // SH to the upper halfword
    pushExp(0, 0, 0);
    applyStimulus(0, 1, 3'b001, 32'h06, 32'h1234ABCD);
    checkOutput("sh_addr", mem_addr, 32'h04);
    checkOutput("sh_wstrb", mem_wstrb, 4'b1100);
    checkOutput("sh_wdata", mem_wdata, 32'hABCDABCD);
    serveMem("sh", 0, 0, 0, 0, 0);
    checkDone("sh");
    checkOutput("ld_hold", load_data, 32'h00000080);

    // LHU, read data two cycles after the grant
    pushExp(0, 1, 32'h0000BEEF);
    applyStimulus(1, 0, 3'b101, 32'h06, 0);
    serveMem("lhu", 0, 1, 2, 32'hBEEF0000, 0);
    checkDone("lhu");

    // Misaligned LW faults immediately without a bus request
    pushExp(1, 1, 32'h0);
    applyStimulus(1, 0, 3'b010, 32'h102, 0);
    checkOutput("misal_noreq", mem_req, 0);
    checkDone("misal");

    // Store with a load-only funct3 is illegal
    pushExp(1, 0, 0);
    applyStimulus(0, 1, 3'b100, 32'h0, 32'h55);
    checkOutput("illst_noreq", mem_req, 0);
    checkDone("illst");

    // LW with grant withheld: timeout, plus a start pulse while busy
    pushExp(1, 1, 32'h0);
    applyStimulus(1, 0, 3'b010, 32'h300, 0);
    reqCycles = 0;
    found     = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (i == 3) begin
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h500;
      end
      if (i == 4) begin
        start = 1'b0; is_store = 1'b0;
      end
      if (done === 1'b1) found = 1;
      else begin
        if (mem_req === 1'b1) reqCycles++;
        @(negedge clk);
      end
    end
    checkOutput("tmo_reqcycles", reqCycles, 16);
    checkOutput("tmo_req_drop", mem_req, 0);
    checkDone("tmo");
    repeat (3) begin
      @(negedge clk);
      checkOutput("no_second_req", mem_req, 0);
      checkOutput("no_second_busy", busy, 0);
    end

    // Reset while waiting for read data
    applyStimulus(1, 0, 3'b010, 32'h400, 0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checkOutput("rstwait_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("rstwait");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rstwait_nodone", done, 0);
    end

    // Fresh SB after reset
    pushExp(0, 1, 32'h0);
    applyStimulus(0, 1, 3'b000, 32'h03, 32'h000000A5);
    checkOutput("sb_addr", mem_addr, 32'h0);
    checkOutput("sb_wstrb", mem_wstrb, 4'b1000);
    checkOutput("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    serveMem("sb", 0, 0, 0, 0, 0);
    checkDone("sb");

    checkOutput("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit directly downstream of the execute-stage ALU; consumes the ALU result as the effective address and rs2 as store data.
- Issues word-aligned requests on a req/gnt/rvalid data-memory bus with byte strobes, and sign/zero-extends load data.
- Returns a one-cycle completion pulse to the core; holds busy while a transaction is in flight.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_gnt or mem_rvalid before faulting (≥2).
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request strobe; sampled only while busy=0
- is_load  input  1  operation is a load
- is_store  input  1  operation is a store
- funct3  input  3  RV32I width/sign code
- addr  input  32  effective address (ALU output)
- store_data  input  32  rs2 value
- busy  output  1  transaction in flight
- done  output  1  one-cycle completion pulse
- fault  output  1  valid with done; misaligned, illegal funct3, or timeout
- load_data  output  32  extended load result; valid with done for loads
- mem_req  output  1  memory request
- mem_we  output  1  1=write
- mem_addr  output  32  {addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte enables
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read data

Behaviour:
- Clock/reset: single clk, reset asynchronous active-low (rst_n). Reset: state IDLE, all outputs 0, counter 0. Reset mid-transaction aborts it with no done pulse.
- Accept: IDLE, start=1, exactly one of is_load/is_store set. Otherwise ignored. start while busy=1 ignored. Latch addr, store_data, funct3, and direction on acceptance.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- Misalignment: H with addr[0]=1; W with addr[1:0]≠0.
- Illegal or misaligned: IDLE→DONE with fault=1. No mem_req is ever raised.
- FSM:
  - IDLE→REQ on legal accept.
  - REQ: mem_req=1, addr/we/wdata/wstrb held stable until mem_gnt. On gnt: store→DONE, load→WAIT.
  - WAIT: on mem_rvalid, capture and extend data →DONE.
  - DONE: done=1 for exactly one cycle →IDLE.
- Timing: busy=1 in REQ, WAIT, DONE. Minimum latency is accept→done 2 cycles for a store with same-cycle gnt and 3 cycles for a load with rvalid the cycle after gnt.
- Strobes/wdata:
  - SB: wstrb=1<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH: wstrb=addr[1]?1100:0011, wdata={2{sd[15:0]}}.
  - SW: 1111, sd.
  - Loads: mem_wstrb=0, mem_we=0.
- Load extraction: byte lane addr[1:0] or halfword lane addr[1]; sign-extend for LB/LH, zero-extend for LBU/LHU.
- load_data holds its value until the next load completes. It is 0 on fault.
- Timeout: counter clears on entering REQ and on entering WAIT, and increments each cycle in that state. Reaching TIMEOUT without gnt or rvalid forces DONE with fault=1 and mem_req dropped.
- mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.
- gnt and rvalid in the same cycle while in REQ: gnt only is taken; rvalid is expected from the next cycle on.

Test Plan:
- Reset, then SW addr=0x100, sd=0xDEADBEEF, gnt in the first REQ cycle → mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, done 2 cycles after start, fault=0.
- LB addr=0x203, rdata=0x80xxxxxx → wstrb=0, mem_addr=0x200, load_data=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH addr=0x06, sd=0x1234ABCD → wstrb=1100, wdata=0xABCDABCD. LHU addr=0x06, rdata=0xBEEF0000 → 0x0000BEEF.
- LW addr=0x102 → done next cycle with fault=1, mem_req never asserted. Store funct3=100 → fault=1.
- LW with gnt withheld for 16 cycles (TIMEOUT=16) → mem_req drops, done+fault. start pulsed while busy → no second transaction.
- rst_n low during WAIT → all outputs 0 immediately, no done. A fresh SB after reset completes normally.
